// File: rtl/adder_station.sv
// Single-entry reservation station with a fixed-latency ADD/SUB unit.
// Snoops the per-slot data CDB for missing operands and broadcasts on its own ROB slot.
module adder_station #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned RB_SIZE   = 8,
  parameter int unsigned RB_INDEX  = 3,
  parameter int unsigned FU_INDEX  = 4,
  parameter int unsigned REG_INDEX = 5,
  parameter int unsigned FU_ID     = 0,
  parameter int unsigned EXEC_LAT  = 2,
  parameter logic [3:0]  OP_ADD    = 4'h0,
  parameter logic [3:0]  OP_SUB    = 4'h1,
  parameter logic [3:0]  OP_ADDI   = 4'h5,
  parameter logic [3:0]  OP_SUBI   = 4'h6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          kill,
  input  logic [FU_INDEX-1:0]           CDB_inst_fu,
  input  logic [WORD_SIZE-1:0]          CDB_inst_inst,
  input  logic [RB_INDEX-1:0]           CDB_inst_RBindex,
  output logic [REG_INDEX-1:0]          numj,
  output logic [REG_INDEX-1:0]          numk,
  input  logic [WORD_SIZE-1:0]          vj,
  input  logic [WORD_SIZE-1:0]          vk,
  input  logic [RB_INDEX-1:0]           qj,
  input  logic [RB_INDEX-1:0]           qk,
  input  logic                          rdyj,
  input  logic                          rdyk,
  input  logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_data,
  input  logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic [RB_SIZE*WORD_SIZE-1:0]  res_data,
  output logic [RB_SIZE-1:0]            res_valid,
  output logic                          busy
);

  typedef enum logic [1:0] {StIdle, StWait, StExec, StDone} state_e;

  state_e                         state_q, state_d;
  logic [3:0]                     op_q, op_d;
  logic [RB_INDEX-1:0]            rb_q, rb_d;
  logic [WORD_SIZE-1:0]           vj_q, vj_d, vk_q, vk_d;
  logic [RB_INDEX-1:0]            qj_q, qj_d, qk_q, qk_d;
  logic                           pj_q, pj_d, pk_q, pk_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic [RB_SIZE*WORD_SIZE-1:0]   res_data_q, res_data_d;
  logic [RB_SIZE-1:0]             res_valid_q, res_valid_d;

  logic                 accept;
  logic [3:0]           inst_op;
  logic                 is_imm;
  logic [WORD_SIZE-1:0] imm_ext;
  logic [WORD_SIZE-1:0] result;
  logic                 unused_inst;

  assign numj        = CDB_inst_inst[22:18];
  assign numk        = CDB_inst_inst[17:13];
  assign inst_op     = CDB_inst_inst[31:28];
  assign imm_ext     = {{(WORD_SIZE-13){CDB_inst_inst[12]}}, CDB_inst_inst[12:0]};
  assign is_imm      = (inst_op == OP_ADDI) || (inst_op == OP_SUBI);
  assign accept      = (state_q == StIdle) && !kill && (CDB_inst_fu == FU_INDEX'(FU_ID));
  assign unused_inst = ^CDB_inst_inst[27:23];

  assign busy      = (state_q != StIdle);
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;

  always_comb begin
    result = '0;
    case (op_q)
      OP_ADD, OP_ADDI: result = vj_q + vk_q;
      OP_SUB, OP_SUBI: result = vj_q - vk_q;
      default:         result = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rb_d        = rb_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    pj_d        = pj_q;
    pk_d        = pk_q;
    cnt_d       = cnt_q;
    res_data_d  = '0;
    res_valid_d = '0;

    if (kill) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_d  = inst_op;
            rb_d  = CDB_inst_RBindex;
            cnt_d = '0;
            pj_d  = 1'b0;
            pk_d  = 1'b0;
            if (rdyj) begin
              vj_d = vj;
            end else if (CDB_data_valid[qj]) begin
              vj_d = CDB_data_data[qj*WORD_SIZE +: WORD_SIZE];
            end else begin
              qj_d = qj;
              pj_d = 1'b1;
            end
            if (is_imm) begin
              vk_d = imm_ext;
            end else if (rdyk) begin
              vk_d = vk;
            end else if (CDB_data_valid[qk]) begin
              vk_d = CDB_data_data[qk*WORD_SIZE +: WORD_SIZE];
            end else begin
              qk_d = qk;
              pk_d = 1'b1;
            end
            state_d = (pj_d || pk_d) ? StWait : StExec;
          end
        end
        StWait: begin
          if (pj_q && CDB_data_valid[qj_q]) begin
            vj_d = CDB_data_data[qj_q*WORD_SIZE +: WORD_SIZE];
            pj_d = 1'b0;
          end
          if (pk_q && CDB_data_valid[qk_q]) begin
            vk_d = CDB_data_data[qk_q*WORD_SIZE +: WORD_SIZE];
            pk_d = 1'b0;
          end
          if (!pj_d && !pk_d) begin
            state_d = StExec;
            cnt_d   = '0;
          end
        end
        StExec: begin
          // Output registers are loaded here so they are valid exactly during DONE.
          if (cnt_q == 4'(EXEC_LAT - 1)) begin
            state_d                                  = StDone;
            res_valid_d[rb_q]                        = 1'b1;
            res_data_d[rb_q*WORD_SIZE +: WORD_SIZE]  = result;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      rb_q        <= '0;
      vj_q        <= '0;
      vk_q        <= '0;
      qj_q        <= '0;
      qk_q        <= '0;
      pj_q        <= 1'b0;
      pk_q        <= 1'b0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rb_q        <= rb_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      pj_q        <= pj_d;
      pk_q        <= pk_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: doc/adder_station.md
# adder_station

Single-entry reservation station plus fixed-latency integer adder for the ADD/SUB/ADDI/SUBI class. It sits directly downstream of the reorder buffer's instruction-issue bus. It accepts an instruction addressed to its FU index and reads operand values or tags from the register file and status table. It snoops the per-slot data CDB until both operands are ready, executes, and then broadcasts the result on its reorder-buffer slot of the data CDB for one cycle. It reports `busy` back to the reorder buffer and honours the per-FU kill line on branch squash.

## Interface
- WORD_SIZE, 32, datapath width
- RB_SIZE, 8, reorder-buffer entries and data-CDB slots
- RB_INDEX, 3, reorder-buffer index width
- FU_INDEX, 4, FU id width
- REG_INDEX, 5, register number width
- FU_ID, 0, this unit's FU index
- EXEC_LAT, 2, execute cycles (1..15)
- OP_ADD / OP_SUB / OP_ADDI / OP_SUBI, 4'h0 / 4'h1 / 4'h5 / 4'h6, opcodes held in inst[31:28]
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- kill  in  1  squash this unit; driven by the reorder buffer's reset_out[FU_ID]
- CDB_inst_fu  in  FU_INDEX  target FU of the issue bus
- CDB_inst_inst  in  WORD_SIZE  issued instruction
- CDB_inst_RBindex  in  RB_INDEX  destination reorder-buffer slot
- numj, numk  out  REG_INDEX  source register numbers, combinational from CDB_inst_inst[22:18] and [17:13]
- vj, vk  in  WORD_SIZE  register-file values for numj/numk
- qj, qk  in  RB_INDEX  producing slot for numj/numk
- rdyj, rdyk  in  1  register value is committed, so q is ignored
- CDB_data_data  in  RB_SIZE*WORD_SIZE  data CDB, slot i at bits [i*WORD_SIZE +: WORD_SIZE]
- CDB_data_valid  in  RB_SIZE  data CDB slot valids
- res_data  out  RB_SIZE*WORD_SIZE  this unit's contribution to the data CDB; zero outside the owned slot
- res_valid  out  RB_SIZE  one-hot on the owned slot during DONE, else 0
- busy  out  1  station occupied (state != IDLE)

## Operation
- States: IDLE, WAIT, EXEC, DONE. Reset state is IDLE.
- Reset values: busy=0, res_valid=0, res_data=0; the captured tag, value and counter registers are 0.
- Accept an issue when `CDB_inst_fu==FU_ID`, the state is IDLE and kill=0. On accept, latch the opcode, RBindex and immediate (inst[12:0] sign-extended to WORD_SIZE).
- Operand j: take vj if rdyj. Otherwise take the CDB slot qj if `CDB_data_valid[qj]` in the accept cycle. Otherwise store tag qj and mark it pending.
- Operand k: same rule as operand j for the register forms. For ADDI/SUBI, k is the immediate and is always ready.
- WAIT: each cycle, capture any pending operand whose tag slot is valid on the CDB. Leave for EXEC when both operands are ready after that cycle's capture.
- If both operands are ready at accept, go to EXEC directly.
- EXEC: counter runs EXEC_LAT cycles, then DONE. The result is j+k or j−k, modulo 2^WORD_SIZE; overflow is ignored.
- DONE: for exactly one cycle, `res_valid[RBidx]=1` and the result sits in slot RBidx of res_data. Then go to IDLE.
- The station never snoops its own res_valid to wake itself.
- Opcode outside the four supported: accept anyway, result 0.
- Priority: reset > kill > everything else.
  - kill in any state forces IDLE on the next edge, suppresses any pending DONE output and drops a same-cycle issue.
  - kill while IDLE has no effect.

## Timing
- Issue accepted at edge N with both operands ready: EXEC covers cycles N+1 .. N+EXEC_LAT. DONE (res_valid high) is cycle N+EXEC_LAT+1. busy is low from N+EXEC_LAT+2.
- busy rises in the cycle after the accepting edge. The reorder buffer must not target this FU while busy=1; an issue seen while busy=1 is ignored.
- A new issue is accepted at the earliest in the first cycle with busy=0, i.e. no overlap with DONE.
- A CDB wakeup seen in WAIT cycle M leads to EXEC from M+1.
- res_data and res_valid are registered; there is no combinational path from inputs to these outputs.
- numj/numk are combinational, and vj/vk/qj/qk/rdy* are sampled at the same edge as the issue.

## Test plan
- Reset low for 2 cycles with issue and kill toggling -> busy=0, res_valid=0 throughout and on the first high cycle.
- ADD issue, RBindex=3, rdyj=rdyk=1, vj=7, vk=5, EXEC_LAT=2, accept at edge N -> res_valid=8'b0000_1000 and slot 3 = 12 only in cycle N+3; busy low from N+4.
- SUBI with rdyj=0, qj=5, imm=13'h1FFF (−1); CDB slot 5 valid with 0x10 two cycles later -> result 0x11 on the issued slot, EXEC_LAT+1 cycles after the wakeup.
- SUB with vj=0, vk=1, both ready -> result 32'hFFFF_FFFF (wrap).
- ADD waiting on tag 2 and issued while CDB slot 2 is valid in the same cycle -> operand captured at accept, no WAIT cycle.
- Kill asserted in WAIT, in EXEC, and in the same cycle as an issue -> IDLE next cycle, no res_valid ever, busy=0; a following issue is accepted normally.
